// File: rtl/ascii_dec_parser_if.sv
// Handshake and result bundle for the ASCII decimal parser.
// valid/ready semantics: start is a request that the parser takes only while
// it is idle; there is no ready line, the requester watches busy and the
// one-cycle done pulse marks when value/err are updated.
interface ascii_dec_parser_if #(
  parameter int NDIGITS = 8,
  parameter int W_OUT   = 27
);
  logic                   start;
  logic [NDIGITS*8-1:0]   ascii_in;
  logic                   busy;
  logic                   done;
  logic [W_OUT-1:0]       value;
  logic                   err;

  modport master (
    output start, ascii_in,
    input  busy, done, value, err
  );

  modport slave (
    input  start, ascii_in,
    output busy, done, value, err
  );
endinterface

// File: rtl/ascii_dec_parser.sv
// Sequential ASCII decimal string to binary converter, one digit per clock.
// The string is latched into a shift register on start; each CONV cycle
// consumes the top byte. busy/done are registered copies of the FSM state,
// so they lag the state by one cycle and have no path from the inputs.
module ascii_dec_parser #(
  parameter int NDIGITS       = 8,
  parameter int W_OUT         = 27,
  parameter bit LEAD_SPACE_OK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ascii_dec_parser_if.slave    bus,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NDIGITS*8-1:0]   sreg;
  logic [W_OUT-1:0]       acc;
  logic [CNT_W-1:0]       cnt;
  logic                   werr;
  logic                   seen_digit;

  logic [7:0]             top_byte;
  logic                   is_digit;
  logic                   is_lead_space;
  logic [3:0]             digit;
  logic [W_OUT-1:0]       acc_nxt;

  assign dbg_state = state;

  // Classify the byte under the head of the shift register and form acc*10+digit.
  always_comb begin
    top_byte      = sreg[NDIGITS*8-1 -: 8];
    is_digit      = (top_byte >= 8'h30) && (top_byte <= 8'h39);
    is_lead_space = LEAD_SPACE_OK && (top_byte == 8'h20) && !seen_digit;
    digit         = is_digit ? top_byte[3:0] : 4'd0;
    acc_nxt       = (acc << 3) + (acc << 1) + W_OUT'(digit);
  end

  // Next-state logic: one IDLE accept, NDIGITS CONV cycles, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(NDIGITS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs; value/err move only when leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      acc        <= '0;
      cnt        <= '0;
      werr       <= 1'b0;
      seen_digit <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.value  <= '0;
      bus.err    <= 1'b0;
    end else begin
      bus.busy <= (state != IDLE);
      bus.done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg       <= bus.ascii_in;
            acc        <= '0;
            cnt        <= '0;
            werr       <= 1'b0;
            seen_digit <= 1'b0;
          end
        end
        CONV: begin
          // Non-digits still shift the accumulator so the column weights stay right.
          acc        <= is_digit ? acc_nxt : ((acc << 3) + (acc << 1));
          werr       <= werr | (!is_digit && !is_lead_space);
          seen_digit <= seen_digit | is_digit;
          sreg       <= sreg << 8;
          cnt        <= cnt + 1'b1;
        end
        DONE: begin
          bus.value <= werr ? '0 : acc;
          bus.err   <= werr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ascii_dec_parser.md
Name: ascii_dec_parser

Overview:
- Sequential decoder for the 8-character ASCII decimal string format our BCD counters produce: one ASCII byte per digit, most significant digit in bits 63:56.
- Parses the string one digit per clock and returns the binary value, flagging malformed characters.
- Sits downstream of the counter and UART/LCD text paths wherever a displayed decimal value must be turned back into a number for comparison or arithmetic.

Parameters:
- NDIGITS, 8, number of ASCII characters in the input string; the input is NDIGITS*8 bits wide.
- W_OUT, 27, width of the binary result; 27 bits holds 99,999,999.
- LEAD_SPACE_OK, 1, when 1, a space (0x20) before the first digit counts as 0; when 0, a space is an error.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- ascii_in  input  NDIGITS*8  string to parse, MSB byte is the most significant digit; sampled only on the cycle start is accepted.
- busy  output  1  high while a conversion is in progress, including the DONE cycle.
- done  output  1  one-cycle pulse when value and err are updated.
- value  output  W_OUT  binary result of the last conversion.
- err  output  1  the last conversion saw an illegal character.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); asserting it forces all state immediately, regardless of clk.
- Reset values: state=IDLE, busy=0, done=0, value=0, err=0, internal shift register, accumulator, digit counter and seen_digit flag all 0.
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - start=1 on a rising edge latches ascii_in into the shift register.
  - Same edge: clears accumulator, counter and the working error flag, and moves to CONV.
  - start=0 keeps the FSM in IDLE.
- CONV: on each edge, process the top byte b of the shift register, then shift the register left by 8.
  - 0x30 ≤ b ≤ 0x39: acc ← acc*10 + (b − 0x30), and set seen_digit.
  - b = 0x20, LEAD_SPACE_OK=1, seen_digit=0: acc ← acc*10 (no error).
  - Any other b, including a space after a digit: set the working error flag and apply acc ← acc*10.
  - Arithmetic is (acc<<3)+(acc<<1)+digit, truncated to W_OUT bits. There is no overflow detection; the defaults cannot overflow.
  - The counter increments every edge. After the NDIGITS-th byte the FSM moves to DONE.
- DONE, one cycle:
  - done=1, busy=1.
  - value ← working error ? 0 : acc.
  - err ← working error.
  - Next state is IDLE.
- Latency: start accepted at edge k → done high for the cycle following edge k+NDIGITS+1 (9 edges with defaults). Throughput is one conversion per NDIGITS+2 cycles.
- busy is high from the edge after start is accepted through the DONE cycle; it is low in IDLE.
- start while busy=1, including during the DONE cycle, is ignored and not queued. ascii_in changes during CONV have no effect.
- value and err hold their values between done pulses. They change only in the DONE cycle or on reset.
- done and busy are registered outputs, with no combinational path from inputs.
- Reset mid-conversion aborts immediately. value and err go to 0, and no done pulse is produced for the aborted conversion.
- Edge cases:
  - All-space input with LEAD_SPACE_OK=1 yields value=0, err=0.
  - A leading '0' is legal.

Test Plan:
- Reset, then start with "00000000" (0x3030303030303030) → done pulse after 9 edges, value=0, err=0, busy high for exactly 9 cycles.
- "12345678" → value=12,345,678 (0x0BC614E), err=0; then "99999999" → value=99,999,999 (0x5F5E0FF).
- "12A45678" → err=1, value=0. Next, "   12345" with LEAD_SPACE_OK=1 → value=12,345, err=0. Next, "12 45678" → err=1.
- start held high continuously with alternating inputs → a conversion is accepted only in IDLE, one per 10 cycles. ascii_in changed on the edge after acceptance does not alter the result.
- Start "87654321", then drop rst_n asynchronously at the 4th CONV cycle, mid-period → busy, done, value and err are 0 immediately; no done pulse follows. A new start after release → value=87,654,321.
- value holds 12,345,678 across 20 idle cycles with random ascii_in and start=0; it changes only on the next done pulse.
